pad_stream_arbiter: RTL and testbench

- Shares one right-zero-pad width adapter and one output register between two valid/ready requesters, A and B, whose fields differ in width.
- Typical use: merging two mantissa/fraction streams of different precision into a single fixed-width accumulator or encoder port.
- Arbitration is round-robin with a bounded burst. Each accepted word is left-aligned to OUT_WIDTH and tagged with its source.

---
 rtl/pad_stream_arbiter.sv | 122 ++++++++++++
 tb/tb_pad_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_stream_arbiter.sv
// Round-robin arbiter between two valid/ready requesters of different widths,
// feeding one left-aligned (right-zero-padded or truncated) output register.
module pad_stream_arbiter #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 12,
  parameter int OUT_WIDTH = 16,
  parameter int BURST     = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 a_valid,
  input  logic [A_WIDTH-1:0]   a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [B_WIDTH-1:0]   b_data,
  output logic                 b_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_src,
  output logic                 out_inexact,
  input  logic                 out_ready
);

  localparam int MAX_W = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  // Returns {inexact, aligned}; d is zero-extended from its true width w.
  function automatic logic [OUT_WIDTH:0] align(input logic [MAX_W-1:0] d, input int w);
    logic [OUT_WIDTH-1:0] o;
    logic                 inx;
    int                   j;
    o   = '0;
    inx = 1'b0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      j = i + w - OUT_WIDTH;
      if (j >= 0 && j < MAX_W) o[i] = d[j];
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - OUT_WIDTH) inx = inx | d[i];
    end
    return {inx, o};
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_src_q, out_src_d;
  logic                 out_inexact_q, out_inexact_d;
  logic                 last_q, last_d;
  logic                 fresh_q, fresh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 load, gnt_a, gnt_b, keep;
  logic [OUT_WIDTH:0]   aligned;

  always_comb begin
    load  = ~out_valid_q | out_ready;
    // Right after reset nobody has a burst to keep, so contention goes to A.
    keep  = (int'(cnt_q) < BURST - 1) && !fresh_q;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (a_valid && b_valid) begin
      gnt_b = keep ? last_q : ~last_q;
      gnt_a = ~gnt_b;
    end else begin
      gnt_a = a_valid;
      gnt_b = b_valid;
    end
    a_ready = load & gnt_a;
    b_ready = load & gnt_b;

    aligned = gnt_b ? align(MAX_W'(b_data), B_WIDTH) : align(MAX_W'(a_data), A_WIDTH);

    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    out_inexact_d = out_inexact_q;
    last_d        = last_q;
    fresh_d       = fresh_q;
    cnt_d         = cnt_q;
    if (load && (gnt_a || gnt_b)) begin
      out_valid_d   = 1'b1;
      out_data_d    = aligned[OUT_WIDTH-1:0];
      out_inexact_d = aligned[OUT_WIDTH];
      out_src_d     = gnt_b;
      fresh_d       = 1'b0;
      if (gnt_b == last_q) begin
        if (int'(cnt_q) < BURST - 1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d  = '0;
        last_d = gnt_b;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= 1'b0;
      out_inexact_q <= 1'b0;
      last_q        <= 1'b1;
      fresh_q       <= 1'b1;
      cnt_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      out_inexact_q <= out_inexact_d;
      last_q        <= last_d;
      fresh_q       <= fresh_d;
      cnt_q         <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_pad_stream_arbiter.sv
// Directed bench for pad_stream_arbiter: three instances (BURST 4, 1, 2) with a
// 20-bit B source share stimulus and are checked against a run-length model.
module tb_pad_stream_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]  a_data = '0;
  logic [19:0] b_data = '0;

  logic [2:0]  a_rdy, b_rdy, ov, osrc, oinx;
  logic [15:0] od [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pad_stream_arbiter #(.A_WIDTH(8), .B_WIDTH(20), .OUT_WIDTH(16), .BURST(4)) u0 (
    .clock(clock), .resetn(resetn), .a_valid(a_valid), .a_data(a_data), .a_ready(a_rdy[0]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_rdy[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_src(osrc[0]), .out_inexact(oinx[0]), .out_ready(out_ready));
  pad_stream_arbiter #(.A_WIDTH(8), .B_WIDTH(20), .OUT_WIDTH(16), .BURST(1)) u1 (
    .clock(clock), .resetn(resetn), .a_valid(a_valid), .a_data(a_data), .a_ready(a_rdy[1]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_rdy[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_src(osrc[1]), .out_inexact(oinx[1]), .out_ready(out_ready));
  pad_stream_arbiter #(.A_WIDTH(8), .B_WIDTH(20), .OUT_WIDTH(16), .BURST(2)) u2 (
    .clock(clock), .resetn(resetn), .a_valid(a_valid), .a_data(a_data), .a_ready(a_rdy[2]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_rdy[2]), .out_valid(ov[2]), .out_data(od[2]),
    .out_src(osrc[2]), .out_inexact(oinx[2]), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner of the current run, its length, and whether any grant has happened yet.
  int          m_run [3];
  logic        m_last [3];
  logic        m_fresh [3];
  logic        m_ov [3];
  logic [15:0] m_od [3];
  logic        m_src [3];
  logic        m_inx [3];

  function automatic int burst_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 2;
  endfunction

  // 0 = none, 1 = A, 2 = B
  function automatic int model_grant(input int k);
    if (a_valid && !b_valid) return 1;
    if (b_valid && !a_valid) return 2;
    if (!a_valid && !b_valid) return 0;
    if (m_fresh[k]) return 1;
    if (m_run[k] < burst_of(k)) return m_last[k] ? 2 : 1;
    return m_last[k] ? 1 : 2;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 3; k++) begin
        m_run[k] = 1; m_last[k] = 1'b1; m_fresh[k] = 1'b1;
        m_ov[k] = 1'b0; m_od[k] = '0; m_src[k] = 1'b0; m_inx[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int  g;
        logic ld;
        g  = model_grant(k);
        ld = !m_ov[k] || out_ready;
        if (ld && g != 0) begin
          m_ov[k]  = 1'b1;
          m_src[k] = (g == 2);
          if (g == 1) begin
            m_od[k]  = 16'(a_data) * 16'd256;
            m_inx[k] = 1'b0;
          end else begin
            m_od[k]  = 16'(b_data / 20'd16);
            m_inx[k] = (b_data % 20'd16) != 0;
          end
          if (m_src[k] == m_last[k]) m_run[k] = (m_run[k] < burst_of(k)) ? m_run[k] + 1 : m_run[k];
          else begin
            m_run[k]  = 1;
            m_last[k] = m_src[k];
          end
          m_fresh[k] = 1'b0;
        end else if (ld) begin
          m_ov[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      for (int k = 0; k < 3; k++) begin
        int   g;
        logic ld;
        g  = model_grant(k);
        ld = !m_ov[k] || out_ready;
        check($sformatf("a_ready[%0d]", k), 32'(a_rdy[k]), 32'(ld && g == 1));
        check($sformatf("b_ready[%0d]", k), 32'(b_rdy[k]), 32'(ld && g == 2));
        check($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_ov[k]));
        if (m_ov[k]) begin
          check($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(m_od[k]));
          check($sformatf("out_src[%0d]", k), 32'(osrc[k]), 32'(m_src[k]));
          check($sformatf("out_inexact[%0d]", k), 32'(oinx[k]), 32'(m_inx[k]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    #12;
    resetn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  seq0, seq1, seq2;
    logic [15:0] held;

    #3;
    check("reset out_valid", 32'(ov), 32'h0);
    check("reset out_data", 32'(od[0]), 32'h0);
    check("reset src_inexact", 32'({osrc, oinx}), 32'h0);
    #10;
    resetn = 1'b1;
    step();

    // Narrow A padded on the right
    a_valid = 1'b1; a_data = 8'hA5;
    step();
    a_valid = 1'b0;
    @(negedge clock);
    check("pad A data", 32'(od[0]), 32'hA500);
    check("pad A src/inexact", 32'({osrc[0], oinx[0]}), 32'h0);
    step();

    // Wide B truncated, with and without lost bits
    b_valid = 1'b1; b_data = 20'hABCD1;
    step();
    b_data = 20'hABCD0;
    @(negedge clock);
    check("trunc B data", 32'(od[0]), 32'hABCD);
    check("trunc B inexact=1", 32'(oinx[0]), 32'h1);
    step();
    b_valid = 1'b0;
    @(negedge clock);
    check("trunc B inexact=0", 32'(oinx[0]), 32'h0);
    check("trunc B src", 32'(osrc[0]), 32'h1);

    // Contention from reset
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_data = 8'(i + 1); b_data = 20'(i * 20'h11111);
      @(posedge clock);
      @(negedge clock);
      seq0[i] = osrc[0]; seq1[i] = osrc[1]; seq2[i] = osrc[2];
      #4;
    end
    check("burst4 src sequence", 32'(seq0), 32'h000000F0);
    check("burst1 src sequence", 32'(seq1), 32'h000000AA);
    check("burst2 src sequence", 32'(seq2), 32'h000000CC);

    // Stall with both valid
    step();
    out_ready = 1'b0;
    step();
    held = od[0];
    for (int i = 0; i < 5; i++) begin
      a_data = 8'(8'h30 + i); b_data = 20'(20'h40000 + i);
      step();
    end
    check("stall data held", 32'(od[0]), 32'(held));
    check("stall no ready", 32'({a_rdy, b_rdy}), 32'h0);
    out_ready = 1'b1;
    @(negedge clock);
    check("release one ready", 32'(a_rdy[0] ^ b_rdy[0]), 32'h1);
    step();

    // Lone B stream, then A arrives
    do_reset();
    a_valid = 1'b0; b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_data = 20'(20'h12345 * (i + 1));
      step();
    end
    a_valid = 1'b1; a_data = 8'h5A;
    @(negedge clock);
    check("A after B run", 32'({a_rdy, b_rdy}), 32'h38);
    step();

    // Mixed traffic with backpressure
    for (int i = 0; i < 40; i++) begin
      a_valid = (i % 3) != 0;
      b_valid = (i % 4) != 1;
      out_ready = (i % 5) != 2;
      a_data = 8'(i * 7 + 3);
      b_data = 20'(i * 12345);
      step();
    end

    // Asynchronous reset while holding a word
    a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset clears out_valid", 32'(ov), 32'h0);
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    #4;
    resetn = 1'b1;
    @(negedge clock);
    check("post reset A wins", 32'({a_rdy, b_rdy}), 32'h38);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
